// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Items shared by the parametrised UART blocks:
//   - parity mode constants (PARITY_NONE / PARITY_ODD / PARITY_EVEN)
//   - receiver FSM state encoding (rx_state_e)
//   - divisor width and oversampling rate
//   - div_calc(clk, baud): rounded clocks-per-sample divisor
//   - BAUD_TABLE / baud_div(): selectable line rates indexed by a 3-bit code
//   - majority3(): 2-of-3 vote used for the per-bit decision
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Samples per bit period; the bit decision uses samples 7, 8 and 9.
    localparam int OVERSAMPLE_RATE = 16;

    // Wide enough for slow line rates on fast clocks.
    localparam int DIV_W = 16;

    // Line rates selectable at run time; codes 5..7 alias the fastest rate.
    localparam int BAUD_TABLE [8] = '{9600, 19200, 38400, 57600,
                                      115200, 115200, 115200, 115200};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_e;

    // round(clk / (baud * 16)), never below 1 so the tick counter stays legal.
    function automatic int div_calc(input longint clk, input longint baud);
        longint d;
        d = (clk + baud * 8) / (baud * OVERSAMPLE_RATE);
        if (d < 1) d = 1;
        return int'(d);
    endfunction

    // Divisor for a table entry at the given clock frequency.
    function automatic logic [DIV_W-1:0] baud_div(input int clk_hz, input logic [2:0] sel);
        return DIV_W'(div_calc(longint'(clk_hz), longint'(BAUD_TABLE[sel])));
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Oversampling tick generator: emits a one-cycle tick every 'div' clocks while
// enabled. 'clear' restarts the count so the first tick lands exactly 'div'
// clocks later (used to phase-align sampling to a detected start edge).
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   clear  in   restart the count (takes priority over enable)
//   enable in   count while high
//   div    in   clocks per tick (>= 1)
//   tick   out  one-cycle pulse at the end of each tick period
// -----------------------------------------------------------------------------
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            // '>=' also recovers if div shrinks below the running count.
            if (cnt_q >= div - DIV_W'(1)) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
// Parametrised asynchronous serial receiver: DATA_BITS data bits (LSB first),
// optional odd/even parity, 1 or 2 stop bits, 16x oversampling with a 2-of-3
// vote on samples 7, 8, 9 of every bit.
//
// Optional feature (macro UART_RX_BAUD_SET_EN):
//   defined   -> extra input Baud_set[2:0] picks the line rate from a table
//                (9600/19200/38400/57600/115200, codes 5..7 = 115200) at
//                CLK_FREQ; BAUD is ignored. Baud_set is latched only in IDLE.
//   undefined -> divisor fixed from BAUD.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset      in   synchronous active-high reset
//   uart_rx    in   asynchronous serial line, idle high
//   Baud_set   in   [2:0] line-rate select (only with UART_RX_BAUD_SET_EN)
//   Rx_Data    out  [DATA_BITS-1:0] last received data, held until next frame
//   Rx_Done    out  one-cycle pulse: frame complete, outputs updated
//   Parity_Err out  parity mismatch of the last frame (0 without parity)
//   Frame_Err  out  a stop bit of the last frame voted low
//   Busy       out  high from confirmed start bit until the frame ends
// -----------------------------------------------------------------------------
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD        = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 uart_rx,
`ifdef UART_RX_BAUD_SET_EN
    input  logic [2:0]           Baud_set,
`endif
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Rx_Done,
    output logic                 Parity_Err,
    output logic                 Frame_Err,
    output logic                 Busy
);

    localparam int SAMPLE_W = $clog2(OVERSAMPLE);
    localparam logic [SAMPLE_W-1:0] SAMPLE_7 = SAMPLE_W'(7);
    localparam logic [SAMPLE_W-1:0] SAMPLE_8 = SAMPLE_W'(8);
    localparam logic [SAMPLE_W-1:0] SAMPLE_9 = SAMPLE_W'(9);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic PAR_ON     = (PARITY_MODE == PARITY_ODD) || (PARITY_MODE == PARITY_EVEN);
    localparam logic PAR_INVERT = (PARITY_MODE == PARITY_ODD);

    // Synchroniser (sync1, sync2) plus a history flop for edge detection.
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic sync3_q, sync3_d;

    rx_state_e              state_q, state_d;
    logic [SAMPLE_W-1:0]    sample_cnt_q, sample_cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic                   s7_q, s7_d;
    logic                   s8_q, s8_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_err_acc_q, par_err_acc_d;
    logic                   frame_err_acc_q, frame_err_acc_d;

    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_done_q, rx_done_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   busy_q, busy_d;

    logic                   line;
    logic                   fall;
    logic                   vote;
    logic [SAMPLE_W-1:0]    sample_nxt;
    logic                   tick;
    logic                   tick_clear;
    logic [DIV_W-1:0]       tick_div;

`ifdef UART_RX_BAUD_SET_EN
    logic [DIV_W-1:0] div_q, div_d;
    assign tick_div = div_q;
`else
    localparam logic [DIV_W-1:0] FIXED_DIV = DIV_W'(div_calc(longint'(CLK_FREQ), longint'(BAUD)));
    assign tick_div = FIXED_DIV;
`endif

    assign line       = sync2_q;
    assign fall       = sync3_q & ~sync2_q;
    assign sample_nxt = sample_cnt_q + SAMPLE_W'(1);
    // s9 is the live line at the sample-9 tick; s7/s8 were captured earlier.
    assign vote       = majority3(s7_q, s8_q, line);

    uart_baud_tick u_tick (
        .clk    (Clk),
        .reset  (Reset),
        .clear  (tick_clear),
        .enable (state_q != ST_IDLE),
        .div    (tick_div),
        .tick   (tick)
    );

    always_comb begin
        sync1_d         = uart_rx;
        sync2_d         = sync1_q;
        sync3_d         = sync2_q;
        state_d         = state_q;
        sample_cnt_d    = sample_cnt_q;
        bit_cnt_d       = bit_cnt_q;
        s7_d            = s7_q;
        s8_d            = s8_q;
        shift_d         = shift_q;
        par_err_acc_d   = par_err_acc_q;
        frame_err_acc_d = frame_err_acc_q;
        rx_data_d       = rx_data_q;
        rx_done_d       = 1'b0;
        parity_err_d    = parity_err_q;
        frame_err_d     = frame_err_q;
        busy_d          = busy_q;
        tick_clear      = 1'b0;
`ifdef UART_RX_BAUD_SET_EN
        div_d           = div_q;
`endif

        case (state_q)
            ST_IDLE: begin
`ifdef UART_RX_BAUD_SET_EN
                // Rate is latched only between frames.
                div_d = baud_div(CLK_FREQ, Baud_set);
`endif
                if (fall) begin
                    state_d         = ST_START;
                    sample_cnt_d    = '0;
                    bit_cnt_d       = '0;
                    par_err_acc_d   = 1'b0;
                    frame_err_acc_d = 1'b0;
                    tick_clear      = 1'b1;
                end
            end

            ST_WAIT_IDLE: begin
                if (line) state_d = ST_IDLE;
            end

            default: begin
                // Every bit-level state decides at sample 9 and moves on
                // mid-bit; the following sample 7/8 captures belong to the
                // next bit because the counter wraps at 16.
                if (tick) begin
                    sample_cnt_d = sample_nxt;
                    if (sample_nxt == SAMPLE_7) s7_d = line;
                    if (sample_nxt == SAMPLE_8) s8_d = line;
                    if (sample_nxt == SAMPLE_9) begin
                        if (state_q == ST_START) begin
                            if (!vote) begin
                                state_d = ST_DATA;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = ST_IDLE;   // glitch, no outputs
                            end
                        end else if (state_q == ST_DATA) begin
                            shift_d = {vote, shift_q[DATA_BITS-1:1]};
                            if (bit_cnt_q == LAST_DATA) begin
                                bit_cnt_d = '0;
                                state_d   = PAR_ON ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 4'd1;
                            end
                        end else if (state_q == ST_PARITY) begin
                            par_err_acc_d = (vote != ((^shift_q) ^ PAR_INVERT));
                            state_d       = ST_STOP;
                        end else begin
                            frame_err_acc_d = frame_err_acc_q | ~vote;
                            if (bit_cnt_q == LAST_STOP) begin
                                rx_data_d    = shift_q;
                                parity_err_d = PAR_ON & par_err_acc_q;
                                frame_err_d  = frame_err_acc_q | ~vote;
                                rx_done_d    = 1'b1;
                                busy_d       = 1'b0;
                                bit_cnt_d    = '0;
                                // Leaving at mid-stop lets a zero-gap frame
                                // start on the very next falling edge.
                                state_d      = line ? ST_IDLE : ST_WAIT_IDLE;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 4'd1;
                            end
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q         <= 1'b1;
            sync2_q         <= 1'b1;
            sync3_q         <= 1'b1;
            state_q         <= ST_IDLE;
            sample_cnt_q    <= '0;
            bit_cnt_q       <= '0;
            s7_q            <= 1'b0;
            s8_q            <= 1'b0;
            shift_q         <= '0;
            par_err_acc_q   <= 1'b0;
            frame_err_acc_q <= 1'b0;
            rx_data_q       <= '0;
            rx_done_q       <= 1'b0;
            parity_err_q    <= 1'b0;
            frame_err_q     <= 1'b0;
            busy_q          <= 1'b0;
`ifdef UART_RX_BAUD_SET_EN
            div_q           <= baud_div(CLK_FREQ, 3'd0);
`endif
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            sync3_q         <= sync3_d;
            state_q         <= state_d;
            sample_cnt_q    <= sample_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            s7_q            <= s7_d;
            s8_q            <= s8_d;
            shift_q         <= shift_d;
            par_err_acc_q   <= par_err_acc_d;
            frame_err_acc_q <= frame_err_acc_d;
            rx_data_q       <= rx_data_d;
            rx_done_q       <= rx_done_d;
            parity_err_q    <= parity_err_d;
            frame_err_q     <= frame_err_d;
            busy_q          <= busy_d;
`ifdef UART_RX_BAUD_SET_EN
            div_q           <= div_d;
`endif
        end
    end

    assign Rx_Data    = rx_data_q;
    assign Rx_Done    = rx_done_q;
    assign Parity_Err = (PARITY_MODE == PARITY_NONE) ? 1'b0 : parity_err_q;
    assign Frame_Err  = frame_err_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
// Three receivers share clock and reset:
//   dut0: defaults (no parity, 1 stop) at 9600
//   dut1: even parity at 9600
//   dut2: 115200 (Baud_set = 4 when UART_RX_BAUD_SET_EN is defined)
// CLK_FREQ is 1.8432 MHz so bit periods are exact: 192 clocks at 9600 and
// 16 clocks at 115200. Only one receiver is exercised at a time, so a single
// expected queue of {id, parity_err, frame_err, data} entries suffices.
// -----------------------------------------------------------------------------
module tb_uart_rx_param;

    localparam int CLK_FREQ = 1843200;
    localparam int BIT_SLOW = 192;
    localparam int BIT_FAST = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] rx_line = 3'b111;
    logic [7:0] rx_data [3];
    logic [2:0] done;
    logic [2:0] perr;
    logic [2:0] ferr;
    logic [2:0] busy;

    logic [11:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          done_cnt [3] = '{0, 0, 0};
    logic [2:0]  done_prev = 3'b000;
    logic        busy_mid = 1'b0;

    // ---------------------------------------------------------------- clock
    always #5 clk = ~clk;

    initial begin
        #(600000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- DUTs
    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(9600)) u_dut0 (
        .Clk(clk), .Reset(reset), .uart_rx(rx_line[0]),
`ifdef UART_RX_BAUD_SET_EN
        .Baud_set(3'd0),
`endif
        .Rx_Data(rx_data[0]), .Rx_Done(done[0]), .Parity_Err(perr[0]),
        .Frame_Err(ferr[0]), .Busy(busy[0])
    );

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(9600), .PARITY_MODE(2)) u_dut1 (
        .Clk(clk), .Reset(reset), .uart_rx(rx_line[1]),
`ifdef UART_RX_BAUD_SET_EN
        .Baud_set(3'd0),
`endif
        .Rx_Data(rx_data[1]), .Rx_Done(done[1]), .Parity_Err(perr[1]),
        .Frame_Err(ferr[1]), .Busy(busy[1])
    );

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(115200)) u_dut2 (
        .Clk(clk), .Reset(reset), .uart_rx(rx_line[2]),
`ifdef UART_RX_BAUD_SET_EN
        .Baud_set(3'd4),
`endif
        .Rx_Data(rx_data[2]), .Rx_Done(done[2]), .Parity_Err(perr[2]),
        .Frame_Err(ferr[2]), .Busy(busy[2])
    );

    // ---------------------------------------------------------------- checker
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------- scoreboard
    always @(negedge clk) begin
        logic [11:0] e;
        for (int i = 0; i < 3; i++) begin
            if (done[i]) begin
                done_cnt[i]++;
                check($sformatf("dut%0d_done_width", i), {15'd0, done_prev[i]}, 16'd0);
                check($sformatf("dut%0d_done_expected", i), {15'd0, exp_q.size() != 0}, 16'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("dut%0d_frame", i),
                          {4'd0, 2'(i), perr[i], ferr[i], rx_data[i]}, {4'd0, e});
                end
            end
        end
        done_prev = done;
    end

    // ---------------------------------------------------------------- drivers
    // Drives start, 8 data bits LSB first, optional parity, one stop bit, then
    // idle_bits of high line. reset_pos pulses Reset for one cycle in the
    // middle of that frame position (0 = start, 1..8 = data bits).
    task automatic send_frame(input int id, input logic [7:0] data, input int bit_clks,
                              input bit use_par, input logic par_bit, input logic stop_bit,
                              input int idle_bits, input int reset_pos);
        logic fb [12];
        int   nb;
        nb = 0;
        fb[nb] = 1'b0; nb = nb + 1;
        for (int b = 0; b < 8; b++) begin
            fb[nb] = data[b]; nb = nb + 1;
        end
        if (use_par) begin
            fb[nb] = par_bit; nb = nb + 1;
        end
        fb[nb] = stop_bit; nb = nb + 1;
        for (int p = 0; p < nb; p++) begin
            rx_line[id] = fb[p];
            for (int c = 0; c < bit_clks; c++) begin
                @(negedge clk);
                reset = (p == reset_pos) && (c == bit_clks / 2);
                if (p == 3 && c == bit_clks / 2) busy_mid = busy[id];
            end
        end
        reset = 1'b0;
        if (idle_bits > 0) begin
            rx_line[id] = 1'b1;
            repeat (idle_bits * bit_clks) @(negedge clk);
        end
    endtask

    task automatic wait_drain(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check(tag, 16'(exp_q.size()), 16'd0);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int snap;
        logic [7:0] pattern [4];
        pattern = '{8'h55, 8'hAA, 8'hF0, 8'h0F};

        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state.
        check("reset_rx_data", {8'd0, rx_data[0]}, 16'd0);
        check("reset_rx_done", {13'd0, done}, 16'd0);
        check("reset_parity_err", {13'd0, perr}, 16'd0);
        check("reset_frame_err", {13'd0, ferr}, 16'd0);
        check("reset_busy", {13'd0, busy}, 16'd0);

        // Four clean frames, one idle bit between them.
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({2'd0, 1'b0, 1'b0, pattern[k]});
            send_frame(0, pattern[k], BIT_SLOW, 1'b0, 1'b0, 1'b1, 1, -1);
            if (k == 0) check("busy_mid_frame", {15'd0, busy_mid}, 16'd1);
        end
        wait_drain("clean_frames_drained", 4 * BIT_SLOW);
        check("busy_after_frames", {15'd0, busy[0]}, 16'd0);

        // Short low glitch on an idle line: rejected at the start vote.
        snap = done_cnt[0];
        rx_line[0] = 1'b0;
        repeat (40) @(negedge clk);
        rx_line[0] = 1'b1;
        repeat (3 * BIT_SLOW) @(negedge clk);
        check("glitch_no_done", 16'(done_cnt[0] - snap), 16'd0);
        check("glitch_busy_idle", {15'd0, busy[0]}, 16'd0);

        // Stop bit low followed by a stuck-low line.
        snap = done_cnt[0];
        exp_q.push_back({2'd0, 1'b0, 1'b1, 8'h3C});
        send_frame(0, 8'h3C, BIT_SLOW, 1'b0, 1'b0, 1'b0, 0, -1);
        repeat (20 * BIT_SLOW) @(negedge clk);
        wait_drain("frame_err_drained", BIT_SLOW);
        check("break_single_done", 16'(done_cnt[0] - snap), 16'd1);
        check("break_busy_low", {15'd0, busy[0]}, 16'd0);
        rx_line[0] = 1'b1;
        repeat (BIT_SLOW) @(negedge clk);
        exp_q.push_back({2'd0, 1'b0, 1'b0, 8'h81});
        send_frame(0, 8'h81, BIT_SLOW, 1'b0, 1'b0, 1'b1, 1, -1);
        wait_drain("after_break_drained", 2 * BIT_SLOW);

        // Reset pulse during data bit 3; 0xF8 keeps the line high from bit 3
        // on so the aborted tail cannot look like a new start.
        snap = done_cnt[0];
        send_frame(0, 8'hF8, BIT_SLOW, 1'b0, 1'b0, 1'b1, 1, 4);
        check("abort_no_done", 16'(done_cnt[0] - snap), 16'd0);
        check("abort_rx_data", {8'd0, rx_data[0]}, 16'd0);
        check("abort_frame_err", {15'd0, ferr[0]}, 16'd0);
        check("abort_busy", {15'd0, busy[0]}, 16'd0);
        exp_q.push_back({2'd0, 1'b0, 1'b0, 8'hC3});
        send_frame(0, 8'hC3, BIT_SLOW, 1'b0, 1'b0, 1'b1, 1, -1);
        wait_drain("after_abort_drained", 2 * BIT_SLOW);

        // Even parity: 0x5A has four ones, so the correct parity bit is 0.
        exp_q.push_back({2'd1, 1'b1, 1'b0, 8'h5A});
        send_frame(1, 8'h5A, BIT_SLOW, 1'b1, 1'b1, 1'b1, 1, -1);
        exp_q.push_back({2'd1, 1'b0, 1'b0, 8'h5A});
        send_frame(1, 8'h5A, BIT_SLOW, 1'b1, 1'b0, 1'b1, 1, -1);
        wait_drain("parity_drained", 2 * BIT_SLOW);

        // Fast rate, two frames with no idle gap between them.
        exp_q.push_back({2'd2, 1'b0, 1'b0, 8'h12});
        exp_q.push_back({2'd2, 1'b0, 1'b0, 8'h34});
        send_frame(2, 8'h12, BIT_FAST, 1'b0, 1'b0, 1'b1, 0, -1);
        send_frame(2, 8'h34, BIT_FAST, 1'b0, 1'b0, 1'b1, 2, -1);
        wait_drain("back_to_back_drained", 4 * BIT_FAST);
        check("fast_done_count", 16'(done_cnt[2]), 16'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
